// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision add/subtract sequencer over one 8-bit adder slice
// One byte per clock, LSB first; carry chained through a register between bytes.
module mp_add_seq #(
    parameter int WORDS = 4,
    localparam int W  = 8 * WORDS,
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   res_reg;

    logic [7:0]     a_byte;
    logic [7:0]     b_byte;
    logic [7:0]     low;
    logic [1:0]     top;
    logic           c7;
    logic [7:0]     slice_sum;
    logic           slice_cout;
    logic [W-1:0]   res_next;
    logic           last;

    // The slice is split at bit 7 so the carry into the MSB is visible for ovf.
    always_comb begin
        a_byte     = a_reg[{cnt, 3'b000} +: 8];
        b_byte     = b_reg[{cnt, 3'b000} +: 8];
        low        = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'd0, carry};
        c7         = low[7];
        top        = {1'b0, a_byte[7]} + {1'b0, b_byte[7]} + {1'b0, c7};
        slice_sum  = {top[0], low[6:0]};
        slice_cout = top[1];
        res_next   = res_reg;
        res_next[{cnt, 3'b000} +: 8] = slice_sum;
        last       = (cnt == CW'(WORDS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_reg <= res_next;
                    carry   <= slice_cout;
                    if (last) begin
                        sum   <= res_next;
                        cout  <= slice_cout;
                        ovf   <= c7 ^ slice_cout;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - directed self-checking bench for mp_add_seq (WORDS=4)
module tb_mp_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    mp_add_seq #(.WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Drive inputs at a negedge, capture on the following posedge (edge 0).
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic cv);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Full op from IDLE: busy cycles 1..4, done with result in cycle 5, done low in cycle 6.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv,
                          input logic [31:0] es, input logic ec, input logic eo);
        @(negedge clk);
        launch(av, bv, sv, cv);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " sum"},  sum, es);
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        chk({tag, " ovf"},  {31'd0, ovf},  {31'd0, eo});
        @(negedge clk);
        chk({tag, " done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst sum",  sum, 32'd0);
        chk("rst cout", {31'd0, cout}, 32'd0);
        chk("rst ovf",  {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;

        run_op("ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("borrow",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Start pulse and operand changes during RUN must be ignored.
        @(negedge clk);
        launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        dones = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                a = '0; b = '0; start = 1'b1;
            end else begin
                start = 1'b0;
                if (c == 3) begin a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; end
            end
            if (done) begin
                dones++;
                chk("ignore done_cycle", c, 32'd5);
                chk("ignore sum", sum, 32'h2345_678A);
            end
            if (c >= 6) chk("ignore idle", {31'd0, busy}, 32'd0);
        end
        chk("ignore done_count", dones, 32'd1);

        // Back-to-back: second start accepted in the done cycle.
        @(negedge clk);
        launch(32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("b2b first done", {31'd0, done}, 32'd1);
        chk("b2b first sum", sum, 32'h0000_000A);
        launch(32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("b2b busy", {31'd0, busy}, 32'd1);
                chk("b2b done_low", {31'd0, done}, 32'd0);
                chk("b2b hold", sum, 32'h0000_000A);
            end else begin
                chk("b2b second done", {31'd0, done}, 32'd1);
                chk("b2b second sum", sum, 32'h0000_0200);
                chk("b2b second cout", {31'd0, cout}, 32'd0);
            end
        end

        // Reset mid-operation discards the partial result.
        run_op("pre_rst", 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
        @(negedge clk);
        launch(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst busy", {31'd0, busy}, 32'd0);
        chk("mid_rst done", {31'd0, done}, 32'd0);
        chk("mid_rst sum",  sum, 32'd0);
        chk("mid_rst cout", {31'd0, cout}, 32'd0);
        chk("mid_rst ovf",  {31'd0, ovf}, 32'd0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("mid_rst quiet", dones, 32'd0);
        run_op("post_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
